// File: rtl/jk_excitation_sequencer.sv
// Drives J/K of an external JK flip-flop so its Q follows a programmed bit pattern,
// then checks the returned Q two cycles after each step and tallies mismatches.
module jk_excitation_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             input_clock1_c_1,
  input  logic             input_input_switch2__preset_2,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             q_in,
  output logic             j_out,
  output logic             k_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             error,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             prev_q, prev_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             v1_q, v1_d, b1_q, b1_d;
  logic [CNT_W-1:0] i1_q, i1_d;
  logic             v2_q, v2_d, b2_q, b2_d;
  logic [CNT_W-1:0] i2_q, i2_d;
  logic [CNT_W-1:0] len_eff;
  logic             bit_now;

  always_comb begin
    len_eff = len;
    if (int'(len) > WIDTH) len_eff = CNT_W'(WIDTH);
  end

  assign bit_now = pat_q[0];

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    v1_d    = 1'b0;
    b1_d    = b1_q;
    i1_d    = i1_q;
    v2_d    = v1_q;
    b2_d    = b1_q;
    i2_d    = i1_q;

    // Stage 2 holds the bit the flip-flop captured on the previous edge
    if (v2_q && (q_in != b2_q)) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (!err_q) begin
        err_d   = 1'b1;
        first_d = i2_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          len_d   = len_eff;
          idx_d   = '0;
          prev_d  = q_in;
          cnt_d   = '0;
          err_d   = 1'b0;
          first_d = '0;
          busy_d  = 1'b1;
          v2_d    = 1'b0;
          state_d = (len_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Minimal excitation: toggle code is never used
        j_d    = !prev_q && bit_now;
        k_d    = prev_q && !bit_now;
        prev_d = bit_now;
        pat_d  = pat_q >> 1;
        v1_d   = 1'b1;
        b1_d   = bit_now;
        i1_d   = idx_q;
        idx_d  = idx_q + CNT_W'(1);
        if (idx_q + CNT_W'(1) == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!v1_q) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clock1_c_1 or negedge input_input_switch2__preset_2) begin
    if (!input_input_switch2__preset_2) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      prev_q  <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      v1_q    <= 1'b0;
      b1_q    <= 1'b0;
      i1_q    <= '0;
      v2_q    <= 1'b0;
      b2_q    <= 1'b0;
      i2_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      v1_q    <= v1_d;
      b1_q    <= b1_d;
      i1_q    <= i1_d;
      v2_q    <= v2_d;
      b2_q    <= b2_d;
      i2_q    <= i2_d;
    end
  end

  assign j_out          = j_q;
  assign k_out          = k_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_count = cnt_q;
  assign error          = err_q;
  assign first_err_idx  = first_q;

endmodule
